// File: rtl/led_frame_scheduler.sv
// Round-robin scheduler sharing one 16-bit LED shift-out engine between NUM_REQ pattern sources.
// Latency: transfer at cycle T -> sh_start at T+1; one frame in flight, optional dedup and periodic refresh.
// Backpressure: req_ready is only offered in IDLE with the shifter idle; requesters hold valid/data until granted.
module led_frame_scheduler #(
    parameter int NUM_REQ        = 2,
    parameter int GW             = 1,
    parameter int DEDUP          = 1,
    parameter int REFRESH_CYCLES = 0,
    parameter int BUSY_TIMEOUT   = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [16*NUM_REQ-1:0]  req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [15:0]            sh_data,
    output logic                   sh_start,
    input  logic                   sh_busy,
    output logic [15:0]            cur_frame,
    output logic [GW-1:0]          grant_id,
    output logic                   sched_busy,
    output logic [7:0]             frame_count,
    output logic                   err_timeout
);

    localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int TW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;

    state_t          state;
    logic [GW-1:0]   rr_ptr;
    logic [RW-1:0]   refresh_cnt;
    logic [TW-1:0]   timer;
    logic            sent_flag;

    logic [NUM_REQ-1:0] vld_rot;
    logic               win_vld;
    int                 win_idx;
    logic [GW-1:0]      win_id;
    logic [GW-1:0]      next_ptr;
    logic [15:0]        win_data;
    logic               xfer;

    // Rotate valids so bit 0 is the requester at rr_ptr; the first set bit wins.
    always_comb begin
        vld_rot = NUM_REQ'({req_valid, req_valid} >> rr_ptr);
        win_vld = 1'b0;
        win_idx = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!win_vld && vld_rot[k]) begin
                win_vld = 1'b1;
                win_idx = int'(rr_ptr) + k;
            end
        end
        if (win_idx >= NUM_REQ) begin
            win_idx = win_idx - NUM_REQ;
        end
        win_id   = GW'(win_idx);
        next_ptr = (win_idx == NUM_REQ - 1) ? '0 : GW'(win_idx + 1);
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (i == win_idx) begin
                win_data = req_data[16*i +: 16];
            end
        end
        xfer      = !rst && (state == IDLE) && !sh_busy && win_vld;
        req_ready = '0;
        if (xfer) begin
            req_ready = NUM_REQ'(1) << win_id;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            sh_data     <= '0;
            sh_start    <= 1'b0;
            cur_frame   <= '0;
            grant_id    <= '0;
            sched_busy  <= 1'b0;
            frame_count <= '0;
            err_timeout <= 1'b0;
            rr_ptr      <= '0;
            refresh_cnt <= '0;
            timer       <= '0;
            sent_flag   <= 1'b0;
        end else begin
            sh_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (xfer) begin
                        cur_frame   <= win_data;
                        grant_id    <= win_id;
                        rr_ptr      <= next_ptr;
                        refresh_cnt <= '0;
                        // A repeat of what the LEDs already show is accepted but not re-shifted.
                        if (!((DEDUP != 0) && sent_flag && (win_data == cur_frame))) begin
                            sh_data    <= win_data;
                            sh_start   <= 1'b1;
                            sched_busy <= 1'b1;
                            state      <= START;
                        end
                    end else if ((REFRESH_CYCLES != 0) && sent_flag && (req_valid == '0)) begin
                        if (refresh_cnt == RW'(REFRESH_CYCLES - 1)) begin
                            sh_data     <= cur_frame;
                            sh_start    <= 1'b1;
                            sched_busy  <= 1'b1;
                            refresh_cnt <= '0;
                            state       <= START;
                        end else begin
                            refresh_cnt <= refresh_cnt + RW'(1);
                        end
                    end
                end
                START: begin
                    timer <= '0;
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (sh_busy) begin
                        state <= WAIT_DONE;
                    end else if (timer == TW'(BUSY_TIMEOUT - 1)) begin
                        err_timeout <= 1'b1;
                        sched_busy  <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                WAIT_DONE: begin
                    if (!sh_busy) begin
                        frame_count <= frame_count + 8'd1;
                        sent_flag   <= 1'b1;
                        sched_busy  <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    sched_busy <= 1'b0;
                    state      <= IDLE;
                end
            endcase
            if (state != IDLE) begin
                refresh_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_led_frame_scheduler.sv
// Bench for led_frame_scheduler: a small shifter model answers sh_start, and a negedge
// monitor scores every shift start and every grant against queued expectations.
module tb_led_frame_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [1:0]  req_ready;
    logic [15:0] sh_data;
    logic        sh_start;
    logic        sh_busy = 1'b0;
    logic [15:0] cur_frame;
    logic [0:0]  grant_id;
    logic        sched_busy;
    logic [7:0]  frame_count;
    logic        err_timeout;

    int checks = 0;
    int failures = 0;
    int busy_len = 3;
    bit shifter_en = 1'b1;
    int sh_cnt = 0;
    logic rst_s;

    logic [15:0] exp_frame_q[$];
    int          exp_grant_q[$];

    led_frame_scheduler #(
        .NUM_REQ(2), .GW(1), .DEDUP(1), .REFRESH_CYCLES(20), .BUSY_TIMEOUT(15)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .sh_data(sh_data), .sh_start(sh_start), .sh_busy(sh_busy),
        .cur_frame(cur_frame), .grant_id(grant_id), .sched_busy(sched_busy),
        .frame_count(frame_count), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // Shifter: busy rises the cycle after sh_start and stays high busy_len cycles.
    initial begin : shifter
        forever begin
            @(posedge clk);
            rst_s = rst;
            #1;
            if (rst_s) begin
                sh_busy = 1'b0;
                sh_cnt  = 0;
            end else if (sh_cnt > 0) begin
                sh_cnt--;
                if (sh_cnt == 0) sh_busy = 1'b0;
            end else if (sh_start && shifter_en) begin
                sh_busy = 1'b1;
                sh_cnt  = busy_len;
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (sh_start) begin
                if (exp_frame_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sh_start_unexpected: got start with sh_data %0h expected no start", sh_data);
                end else begin
                    chk("sh_data", {16'h0, sh_data}, {16'h0, exp_frame_q.pop_front()});
                end
            end
            if ((req_valid & req_ready) != 2'b00) begin
                chk("ready_onehot", $countones(req_ready), 1);
                if (exp_grant_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL grant_unexpected: got ready %b expected no grant", req_ready);
                end else begin
                    chk("grant_winner", ((req_valid & req_ready) == 2'b10) ? 1 : 0, exp_grant_q.pop_front());
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_ready(input int i);
        int n = 0;
        logic [1:0] m;
        m = 2'b01 << i;
        do begin
            @(negedge clk);
            n++;
        end while (((req_ready & m) == 2'b00) && n < 100);
        if ((req_ready & m) == 2'b00) bound_fail("wait_ready");
    endtask

    task automatic send(input int i, input logic [15:0] d);
        req_data[16*i +: 16] = d;
        req_valid = req_valid | (2'b01 << i);
        wait_ready(i);
        @(posedge clk);
        #1 req_valid = req_valid & ~(2'b01 << i);
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((sched_busy || sh_busy) && n < 300);
        if (sched_busy || sh_busy) bound_fail("wait_idle");
    endtask

    initial begin : stim
        int n;
        int bad;

        do_reset();
        @(negedge clk);
        chk("rst_sh_start", sh_start, 0);
        chk("rst_sched_busy", sched_busy, 0);
        chk("rst_frame_count", frame_count, 0);
        chk("rst_err_timeout", err_timeout, 0);
        chk("rst_data_frame", {sh_data, cur_frame}, 0);
        chk("rst_grant_ready", {grant_id, req_ready}, 0);

        // Single request: ready for one cycle, start the next cycle.
        @(posedge clk);
        #1;
        req_data[15:0] = 16'h000F;
        req_valid = 2'b01;
        exp_grant_q.push_back(0);
        exp_frame_q.push_back(16'h000F);
        wait_ready(0);
        @(negedge clk);
        chk("t1_ready_dropped", req_ready, 0);
        chk("t1_sh_start", sh_start, 1);
        chk("t1_sched_busy", sched_busy, 1);
        req_valid = 2'b00;
        wait_idle();
        chk("t1_frame_count", frame_count, 1);
        chk("t1_cur_frame", cur_frame, 16'h000F);
        chk("t1_grant_id", grant_id, 0);

        // Two requesters held valid: alternate grants.
        do_reset();
        req_data = {16'hB002, 16'hA001};
        req_valid = 2'b11;
        for (int g = 0; g < 4; g++) begin
            exp_grant_q.push_back(g % 2);
            exp_frame_q.push_back((g % 2) ? 16'hB002 : 16'hA001);
        end
        bad = 0;
        for (int g = 0; g < 4; g++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
                if (req_ready != 2'b00 && sched_busy) bad++;
            end while (((req_valid & req_ready) == 2'b00) && n < 100);
            if ((req_valid & req_ready) == 2'b00) bound_fail("t2_transfer");
            @(negedge clk);
            chk("t2_grant_id", grant_id, g % 2);
            if (g == 3) req_valid = 2'b00;
        end
        chk("t2_ready_while_busy", bad, 0);
        wait_idle();
        chk("t2_frame_count", frame_count, 4);

        // Duplicate suppression.
        do_reset();
        exp_grant_q.push_back(0);
        exp_frame_q.push_back(16'hFFFF);
        send(0, 16'hFFFF);
        wait_idle();
        chk("t3_first_count", frame_count, 1);
        exp_grant_q.push_back(0);
        send(0, 16'hFFFF);
        repeat (4) @(negedge clk);
        chk("t3_dup_count", frame_count, 1);
        chk("t3_dup_idle", sched_busy, 0);
        exp_grant_q.push_back(1);
        exp_frame_q.push_back(16'h1234);
        send(1, 16'h1234);
        wait_idle();
        chk("t3_new_count", frame_count, 2);
        chk("t3_grant_id", grant_id, 1);

        // Periodic refresh, and a request on the 20th idle cycle pre-empting it.
        do_reset();
        exp_grant_q.push_back(0);
        exp_frame_q.push_back(16'h00FF);
        send(0, 16'h00FF);
        wait_idle();
        exp_frame_q.push_back(16'h00FF);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sh_start && n < 100);
        chk("t4_refresh_interval", n, 20);
        wait_idle();
        chk("t4_refresh_count", frame_count, 2);
        repeat (19) @(posedge clk);
        #1;
        exp_grant_q.push_back(1);
        exp_frame_q.push_back(16'h5A5A);
        send(1, 16'h5A5A);
        wait_idle();
        chk("t4_preempt_count", frame_count, 3);
        chk("t4_cur_frame", cur_frame, 16'h5A5A);

        // Shifter never answers: timeout after 15 cycles in WAIT_BUSY.
        do_reset();
        shifter_en = 1'b0;
        exp_grant_q.push_back(0);
        exp_frame_q.push_back(16'h0001);
        send(0, 16'h0001);
        repeat (15) @(posedge clk);
        @(negedge clk);
        chk("t5_err_early", {err_timeout, sched_busy}, 2'b01);
        @(negedge clk);
        chk("t5_err_set", {err_timeout, sched_busy}, 2'b10);
        chk("t5_frame_count", frame_count, 0);
        shifter_en = 1'b1;
        exp_grant_q.push_back(0);
        exp_frame_q.push_back(16'h0002);
        send(0, 16'h0002);
        wait_idle();
        chk("t5_err_sticky", err_timeout, 1);
        chk("t5_after_count", frame_count, 1);

        // Reset during WAIT_DONE.
        do_reset();
        busy_len = 6;
        exp_grant_q.push_back(0);
        exp_frame_q.push_back(16'h0C0C);
        send(0, 16'h0C0C);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("t6_pre_busy", {sched_busy, sh_busy}, 2'b11);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("t6_rst_ctrl", {sh_start, sched_busy, err_timeout, sh_busy}, 0);
        chk("t6_rst_frames", {sh_data, cur_frame}, 0);
        chk("t6_rst_count", {grant_id, frame_count}, 0);
        busy_len = 3;
        exp_grant_q.push_back(1);
        exp_frame_q.push_back(16'h7777);
        send(1, 16'h7777);
        wait_idle();
        chk("t6_after_count", frame_count, 1);
        chk("t6_after_frame", {grant_id, cur_frame}, {1'b1, 16'h7777});

        chk("sb_frames_left", exp_frame_q.size(), 0);
        chk("sb_grants_left", exp_grant_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
